// File: rtl/aud_pkg.sv
// Shared types and constants for the audio voice sequencer / mixer.
package aud_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } aud_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT,
    COMMIT
  } aud_seq_state_e;

endpackage

// File: rtl/aud_sat16.sv
// Fits a wide signed accumulator into one 16-bit channel.
// AUD_MIX_SATURATE_EN defined: clamp to [-32768, 32767]; undefined: keep low 16 bits.
module aud_sat16 #(
  parameter int ACC_W = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [15:0]      fit
);

`ifdef AUD_MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32'sd32768);

  always_comb begin
    if (acc > MAX_V)      fit = 16'sh7fff;
    else if (acc < MIN_V) fit = 16'sh8000;
    else                  fit = acc[15:0];
  end
`else
  // Upper accumulator bits are intentionally discarded in wrap mode.
  logic unused_hi;
  assign unused_hi = ^acc[ACC_W-1:16];
  assign fit       = acc[15:0];
`endif

endmodule

// File: rtl/aud_voice_seq.sv
// Per-frame voice sequencer: polls enabled voices over req/ack and commits the mixed
// {left, right} sample. Build option AUD_MIX_SATURATE_EN selects clamping (see aud_sat16).
module aud_voice_seq
  import aud_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_req_i,
  input  logic [NUM_VOICES-1:0] voice_en_i,
  output logic [NUM_VOICES-1:0] voice_req_o,
  input  logic [NUM_VOICES-1:0] voice_ack_i,
  input  logic [31:0]           voice_sample_i,
  output logic [31:0]           sample_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int IDX_W = $clog2(NUM_VOICES + 1);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int TMR_W = 8;

  aud_seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_VOICES-1:0]    mask_q, mask_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [31:0]              sample_q, sample_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_q, timeout_d;

  logic [NUM_VOICES-1:0]    sel_oh;
  logic                     mask_hit, ack_hit, expired;
  logic signed [15:0]       fit_l, fit_r;
  aud_sample_t              vs;

  assign vs = voice_sample_i;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) sel_oh[i] = (idx_q == IDX_W'(i));
  end

  assign mask_hit = |(mask_q & sel_oh);
  assign ack_hit  = |(voice_ack_i & sel_oh);
  assign expired  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  aud_sat16 #(.ACC_W(ACC_W)) u_sat_l (.acc(acc_l_q), .fit(fit_l));
  aud_sat16 #(.ACC_W(ACC_W)) u_sat_r (.acc(acc_r_q), .fit(fit_r));

  // NOTE: every signal is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    sample_d  = sample_q;
    done_d    = 1'b0;
    overrun_d = frame_req_i && (state_q != IDLE);
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_req_i) begin
          mask_d  = voice_en_i;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_VOICES)) begin
          state_d = COMMIT;
        end else if (mask_hit) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WAIT: begin
        // An ack in the expiry cycle wins over the timeout.
        if (ack_hit) begin
          acc_l_d = acc_l_q + ACC_W'(vs.l);
          acc_r_d = acc_r_q + ACC_W'(vs.r);
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else if (expired) begin
          timeout_d = 1'b1;
          idx_d     = idx_q + 1'b1;
          state_d   = SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COMMIT: begin
        sample_d = {fit_l, fit_r};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      timer_q   <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      sample_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      sample_q  <= sample_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Request is decoded purely from registered state, so it cannot glitch on input activity.
  assign voice_req_o = (state_q == WAIT) ? sel_oh : '0;
  assign busy_o      = (state_q != IDLE);
  assign sample_o    = sample_q;
  assign done_o      = done_q;
  assign overrun_o   = overrun_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_aud_voice_seq.sv
// Self-checking bench for aud_voice_seq: directed table, corner sequences, random passes vs model.
module tb_aud_voice_seq;

  localparam int NV = 4;
  localparam int T  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          frame_req_i = 1'b0;
  logic [NV-1:0] voice_en_i = '0;
  logic [NV-1:0] voice_req_o;
  logic [NV-1:0] voice_ack_i = '0;
  logic [31:0]   voice_sample_i = '0;
  logic [31:0]   sample_o;
  logic          busy_o, done_o, overrun_o, timeout_o;

  aud_voice_seq #(.NUM_VOICES(NV), .TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .frame_req_i    (frame_req_i),
    .voice_en_i     (voice_en_i),
    .voice_req_o    (voice_req_o),
    .voice_ack_i    (voice_ack_i),
    .voice_sample_i (voice_sample_i),
    .sample_o       (sample_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Voice responder state: what each voice returns and how long it takes.
  logic [NV-1:0]       cur_mask  = '0;
  logic [NV-1:0][31:0] cur_smp   = '0;
  logic [NV-1:0][7:0]  cur_dly   = '0;
  logic [NV-1:0]       cur_never = '0;
  logic                spurious_en = 1'b0;
  int                  bad_req  = 0;
  int                  wait_cnt = 0;
  logic [31:0]         exp_prev = '0;

  always @(negedge clk_i) begin
    voice_ack_i    = spurious_en ? (NV'($urandom) & ~voice_req_o) : '0;
    voice_sample_i = $urandom;
    if (voice_req_o != '0) begin
      if ($countones(voice_req_o) != 1 || (voice_req_o & ~cur_mask) != '0) bad_req++;
      for (int i = 0; i < NV; i++) begin
        if (voice_req_o[i] && !cur_never[i] && wait_cnt == int'(cur_dly[i])) begin
          voice_ack_i[i] = 1'b1;
          voice_sample_i = cur_smp[i];
        end
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [15:0] fit16(input int s);
`ifdef AUD_MIX_SATURATE_EN
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  // Reference: sum of answering voices, and cycle of done from per-voice costs.
  task automatic model_pass(input logic [NV-1:0] mask, input logic [NV-1:0][31:0] smp,
                            input logic [NV-1:0][7:0] dly, input logic [NV-1:0] never,
                            output logic [31:0] s, output int done_cyc, output int n_to);
    int sl = 0, sr = 0;
    logic [31:0] w;
    done_cyc = 3;
    n_to = 0;
    for (int i = 0; i < NV; i++) begin
      if (!mask[i]) begin
        done_cyc += 1;
      end else if (!never[i] && int'(dly[i]) <= T - 1) begin
        w = smp[i];
        sl += int'($signed(w[31:16]));
        sr += int'($signed(w[15:0]));
        done_cyc += 2 + int'(dly[i]);
      end else begin
        n_to++;
        done_cyc += 1 + T;
      end
    end
    s = {fit16(sl), fit16(sr)};
  endtask

  task automatic run_pass(input string name, input logic [NV-1:0] mask, input int ov_at,
                          input logic [31:0] exp_s, input int exp_done, input int exp_to,
                          input int exp_ov);
    int k, to_n = 0, ov_n = 0, busy_bad = 0, hold_bad = 0, done_at = -1;
    bad_req    = 0;
    cur_mask   = mask;
    voice_en_i = mask;
    @(negedge clk_i);
    frame_req_i = 1'b1;
    @(negedge clk_i);
    frame_req_i = 1'b0;
    k = 1;
    while (k <= 300) begin
      if (k == ov_at) begin
        frame_req_i = 1'b1;
        voice_en_i  = ~mask;
      end else begin
        frame_req_i = 1'b0;
      end
      if (overrun_o) ov_n++;
      if (timeout_o) to_n++;
      if (done_o) begin
        done_at = k;
        break;
      end
      if (!busy_o) busy_bad++;
      if (sample_o !== exp_prev) hold_bad++;
      @(negedge clk_i);
      k++;
    end
    frame_req_i = 1'b0;
    check({name, " done cycle"}, done_at, exp_done);
    check({name, " sample"}, sample_o, exp_s);
    check({name, " busy low at done"}, {31'd0, busy_o}, 32'd0);
    check({name, " busy during pass"}, busy_bad, 0);
    check({name, " sample held before commit"}, hold_bad, 0);
    check({name, " timeouts"}, to_n, exp_to);
    check({name, " overruns"}, ov_n, exp_ov);
    check({name, " illegal req"}, bad_req, 0);
    @(negedge clk_i);
    check({name, " done one cycle"}, {31'd0, done_o}, 32'd0);
    check({name, " sample stable"}, sample_o, exp_s);
    exp_prev = exp_s;
  endtask

  typedef struct {
    string               name;
    logic [NV-1:0]       mask;
    logic [NV-1:0][31:0] smp;
    logic [NV-1:0][7:0]  dly;
    logic [NV-1:0]       never;
    logic [31:0]         exp_s;
    int                  exp_done;
    int                  exp_to;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] ms;
    int md, mt, cnt;

    vecs[0] = '{"all_en", 4'b1111, {4{32'h0100FF00}}, '0, 4'b0000, 32'h0400FC00, 11, 0};
    vecs[1] = '{"mask_0101", 4'b0101, {4{32'h10000010}}, '0, 4'b0000, 32'h20000020, 9, 0};
`ifdef AUD_MIX_SATURATE_EN
    vecs[2] = '{"overflow", 4'b1111, {4{32'h70009000}}, '0, 4'b0000, 32'h7FFF8000, 11, 0};
`else
    vecs[2] = '{"overflow", 4'b1111, {4{32'h70009000}}, '0, 4'b0000, 32'hC0004000, 11, 0};
`endif
    vecs[3] = '{"timeout_v1", 4'b1111, {4{32'h00010002}}, '0, 4'b0010, 32'h00030006, 18, 1};
    vecs[4] = '{"all_dis", 4'b0000, {4{32'h12345678}}, '0, 4'b0000, 32'h00000000, 7, 0};

    repeat (2) @(negedge clk_i);
    check("reset sample_o", sample_o, 0);
    check("reset voice_req_o", {28'd0, voice_req_o}, 0);
    check("reset busy_o", {31'd0, busy_o}, 0);
    check("reset done_o", {31'd0, done_o}, 0);
    check("reset overrun_o", {31'd0, overrun_o}, 0);
    check("reset timeout_o", {31'd0, timeout_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int v = 0; v < 5; v++) begin
      cur_smp   = vecs[v].smp;
      cur_dly   = vecs[v].dly;
      cur_never = vecs[v].never;
      run_pass(vecs[v].name, vecs[v].mask, -1, vecs[v].exp_s, vecs[v].exp_done,
               vecs[v].exp_to, 0);
    end

    // Request while busy: one overrun, single commit using the originally latched mask.
    cur_smp = {4{32'h0003FFFF}};
    cur_dly = '0;
    cur_never = '0;
    run_pass("overrun", 4'b1111, 3, 32'h000CFFFC, 11, 0, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (busy_o || done_o) cnt++;
    end
    check("overrun no extra pass", cnt, 0);

    // Reset while a voice is being waited on.
    cur_smp = {4{32'h11112222}};
    cur_never = 4'b0001;
    cur_mask = 4'b0001;
    voice_en_i = 4'b0001;
    @(negedge clk_i);
    frame_req_i = 1'b1;
    @(negedge clk_i);
    frame_req_i = 1'b0;
    @(negedge clk_i);
    check("wait req asserted", {28'd0, voice_req_o}, 32'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid-reset voice_req_o", {28'd0, voice_req_o}, 0);
    check("mid-reset sample_o", sample_o, 0);
    check("mid-reset busy_o", {31'd0, busy_o}, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o || timeout_o) cnt++;
      @(negedge clk_i);
    end
    check("mid-reset no done", cnt, 0);
    exp_prev = '0;

    // Randomised passes with spurious acks on non-polled voices.
    spurious_en = 1'b1;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < NV; i++) begin
        cur_smp[i]   = $urandom;
        cur_dly[i]   = ($urandom_range(0, 4) == 0) ? 8'(T - 1) : 8'($urandom_range(0, 3));
        cur_never[i] = ($urandom_range(0, 5) == 0);
      end
      cur_mask = NV'($urandom);
      model_pass(cur_mask, cur_smp, cur_dly, cur_never, ms, md, mt);
      run_pass($sformatf("rand%0d", p), cur_mask, -1, ms, md, mt, 0);
    end
    spurious_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
